y86_imem_loader: RTL and testbench
==================================

Name: y86_imem_loader

Overview:
Program loader upstream of the Y86 processor core. After a start pulse it zero-fills instruction memory, so unloaded bytes decode as halt (icode 0). It then streams program bytes from a valid/ready byte interface into consecutive memory addresses. It holds the core stalled via cpu_run=0 until the image completes, then releases it. It also reports the byte count, an 8-bit additive checksum and an overflow error.

Parameters:
MEM_BYTES, 1024, instruction memory size in bytes; power of two, >= 4.
ADDR_W, 10, address width; equals log2(MEM_BYTES).

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to begin clear+load; honoured only in IDLE.
in_valid  in  1  a program byte is presented.
in_data  in  8  program byte.
in_last  in  1  qualifies in_data as the final image byte; meaningful only when in_valid=1.
in_ready  out  1  loader accepts a byte this cycle.
mem_we  out  1  instruction memory write strobe.
mem_addr  out  ADDR_W  write address.
mem_wdata  out  8  write data.
cpu_run  out  1  1 = core may execute; 0 = core stalled.
load_done  out  1  image loaded successfully (sticky until rst).
load_err  out  1  overflow error (sticky until rst).
byte_count  out  ADDR_W+1  number of image bytes written.
checksum  out  8  mod-256 sum of image bytes written.

Behaviour:
- Reset, clk edge with rst=1: state=IDLE. All outputs 0. Internal counters 0. rst overrides every other input, including mid-CLEAR or mid-LOAD. Memory contents are not restored.
- All outputs are registered except in_ready, which is decoded from the registered state: in_ready=1 iff state=LOAD.
- Handshake: a byte is accepted on an edge where in_valid=1 and in_ready=1. in_data and in_last must stay stable while in_valid=1 and in_ready=0.
- FSM transitions:
  - IDLE: start=1 -> CLEAR, with the clear counter at 0. Otherwise stay in IDLE.
  - CLEAR: emits one zero write per cycle. Addresses run 0..MEM_BYTES-1 over exactly MEM_BYTES cycles, with mem_we=1 and mem_wdata=0x00. After address MEM_BYTES-1 is issued -> LOAD, with the write pointer at 0. in_ready=0 throughout.
  - LOAD: on an accepted byte with write pointer < MEM_BYTES:
    - next cycle: mem_we=1, mem_addr=pointer, mem_wdata=in_data (one-cycle write latency);
    - pointer+1, byte_count+1, checksum += in_data (mod 256);
    - if in_last=1 -> DONE.
    No accepted byte -> mem_we=0 next cycle; stay in LOAD.
  - Overflow in LOAD: a byte accepted with pointer == MEM_BYTES -> ERROR. No write is issued. Counters and checksum are unchanged. load_err=1 from the next cycle. A final byte that lands exactly on address MEM_BYTES-1 is legal and goes to DONE.
  - DONE: load_done=1 and cpu_run=1 from the cycle after the last byte is accepted. This is the same cycle as that byte's mem_we. Stays in DONE until rst.
  - ERROR: load_err=1, cpu_run=0, in_ready=0. Stays in ERROR until rst.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0).
- in_last=1 on the first accepted byte is legal: a one-byte image.
- byte_count is ADDR_W+1 bits wide so it can represent MEM_BYTES.
- mem_addr holds its last value when mem_we=0.

Test Plan:
- Reset values: hold rst for 3 cycles with start=1 and in_valid=1 -> all outputs 0, in_ready=0, state IDLE. The first cycle after release is still IDLE.
- Clear sweep with MEM_BYTES=16: pulse start -> exactly 16 consecutive cycles of mem_we=1, addresses 0..15, data 0x00, in_ready=0. in_ready=1 on the 17th cycle.
- Load with gaps: send 0x30, gap of 2 idle cycles, 0xF2, then 0x00 with in_last=1. Expected:
  - writes (0,0x30), (1,0xF2), (2,0x00), each one cycle after its accept;
  - byte_count=3, checksum=0x22;
  - cpu_run=1 and load_done=1 together with the write to address 2;
  - in_ready=0 afterwards.
- Exact fill with MEM_BYTES=16: 16 bytes of 0x01, last byte flagged -> DONE, byte_count=16, checksum=0x10, load_err=0.
- Overflow with MEM_BYTES=16: 17 bytes with no in_last -> the 17th is accepted, no write is issued, load_err=1, cpu_run=0. Further in_valid sees in_ready=0.
- Reset mid-LOAD and start ignored:
  - assert start during LOAD -> no effect;
  - assert rst after 5 bytes -> all outputs 0 next cycle;
  - a new start -> full CLEAR sweep restarts at address 0.

Source files
------------

// File: rtl/y86_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : y86_imem_loader
// Description : Zero-fills Y86 instruction memory, then streams a byte image
//               into it and releases the core once the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(MEM_BYTES - 1);
    localparam logic [ADDR_W:0]   C_FULL      = (ADDR_W + 1)'(MEM_BYTES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_cpu_run;
    logic                r_load_done;
    logic                r_load_err;
    logic [ADDR_W:0]     r_byte_count;
    logic [7:0]          r_checksum;
    logic                w_accept;
    logic                w_full;

    assign in_ready = (r_state == S_LOAD);
    assign w_accept = in_valid && (r_state == S_LOAD);
    // The byte counter doubles as the write pointer.
    assign w_full   = (r_byte_count == C_FULL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_mem_addr == C_LAST_ADDR) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_accept) begin
                    if (w_full)       w_state_nxt = S_ERROR;
                    else if (in_last) w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_run    <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_byte_count <= '0;
            r_checksum   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Issue the address-0 clear on the same edge that enters CLEAR.
                    if (start) begin
                        r_mem_we     <= 1'b1;
                        r_mem_addr   <= '0;
                        r_mem_wdata  <= '0;
                        r_byte_count <= '0;
                        r_checksum   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_mem_addr != C_LAST_ADDR) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_full) begin
                            r_load_err <= 1'b1;
                        end else begin
                            r_mem_we     <= 1'b1;
                            r_mem_addr   <= r_byte_count[ADDR_W-1:0];
                            r_mem_wdata  <= in_data;
                            r_byte_count <= r_byte_count + (ADDR_W + 1)'(1);
                            r_checksum   <= r_checksum + in_data;
                            if (in_last) begin
                                r_load_done <= 1'b1;
                                r_cpu_run   <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_run    = r_cpu_run;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign byte_count = r_byte_count;
    assign checksum   = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_y86_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_imem_loader
// Description : Self-checking bench for y86_imem_loader with a 16-byte memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_imem_loader;

    localparam int MB = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_run;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   byte_count;
    logic [7:0]    checksum;

    int errors = 0;
    int checks = 0;

    logic [7:0] obs_mem [MB];
    int         wr_count = 0;

    y86_imem_loader #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_run(cpu_run), .load_done(load_done),
        .load_err(load_err), .byte_count(byte_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Memory image as seen from the write port.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            obs_mem[mem_addr] <= mem_wdata;
            wr_count          <= wr_count + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic start_and_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (MB) tick();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last,
                             input logic exp_we, input logic [AW-1:0] exp_addr);
        bit acc = 0;
        int k = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        while (k < 50) begin
            if (in_ready === 1'b1) begin
                acc = 1;
                break;
            end
            tick();
            k++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL handshake: in_ready=%b required 1 for byte %h", in_ready, d);
        end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (mem_we !== exp_we) begin
            errors++;
            $display("FAIL write_strobe: mem_we=%b required %b (byte %h)", mem_we, exp_we, d);
        end
        if (exp_we) begin
            checks++;
            if ({mem_addr, mem_wdata} !== {exp_addr, d}) begin
                errors++;
                $display("FAIL write_data: addr=%h data=%h required addr=%h data=%h",
                         mem_addr, mem_wdata, exp_addr, d);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_run, load_done, load_err, byte_count,
             checksum, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%h wd=%h run=%b done=%b err=%b cnt=%h sum=%h rdy=%b required all 0",
                     mem_we, mem_addr, mem_wdata, cpu_run, load_done, load_err,
                     byte_count, checksum, in_ready);
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        tick();
        checks++;
        if ({in_ready, mem_we} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: in_ready=%b mem_we=%b required 0 0", in_ready, mem_we);
        end
    endtask

    task automatic test_clear();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < MB; i++) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata, in_ready} !== {1'b1, AW'(i), 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL clear_sweep[%0d]: we=%b addr=%h wd=%h rdy=%b required 1 %h 00 0",
                         i, mem_we, mem_addr, mem_wdata, in_ready, AW'(i));
            end
            tick();
        end
        checks++;
        if ({in_ready, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL clear_end: in_ready=%b mem_we=%b required 1 0", in_ready, mem_we);
        end
    endtask

    task automatic test_load_gaps();
        do_reset();
        start_and_clear();
        send_byte(8'h30, 1'b0, 1'b1, 4'd0);
        repeat (2) begin
            tick();
            checks++;
            if ({mem_we, mem_addr} !== {1'b0, 4'd0}) begin
                errors++;
                $display("FAIL gap_idle: mem_we=%b mem_addr=%h required 0 0", mem_we, mem_addr);
            end
        end
        send_byte(8'hF2, 1'b0, 1'b1, 4'd1);
        send_byte(8'h00, 1'b1, 1'b1, 4'd2);
        checks++;
        if ({cpu_run, load_done, byte_count, checksum} !== {1'b1, 1'b1, 5'd3, 8'h22}) begin
            errors++;
            $display("FAIL gap_result: run=%b done=%b cnt=%0d sum=%h required 1 1 3 22",
                     cpu_run, load_done, byte_count, checksum);
        end
        tick();
        checks++;
        if ({in_ready, mem_we} !== 2'b00) begin
            errors++;
            $display("FAIL gap_after_done: in_ready=%b mem_we=%b required 0 0", in_ready, mem_we);
        end
    endtask

    task automatic test_exact_fill();
        do_reset();
        start_and_clear();
        for (int i = 0; i < MB; i++)
            send_byte(8'h01, (i == MB - 1), 1'b1, AW'(i));
        checks++;
        if ({load_done, cpu_run, load_err, byte_count, checksum} !== {3'b110, 5'd16, 8'h10}) begin
            errors++;
            $display("FAIL exact_fill: done=%b run=%b err=%b cnt=%0d sum=%h required 1 1 0 16 10",
                     load_done, cpu_run, load_err, byte_count, checksum);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        start_and_clear();
        for (int i = 0; i < MB; i++)
            send_byte(8'h02, 1'b0, 1'b1, AW'(i));
        send_byte(8'h77, 1'b0, 1'b0, 4'd0);
        checks++;
        if ({load_err, cpu_run, load_done, byte_count, checksum} !== {3'b100, 5'd16, 8'h20}) begin
            errors++;
            $display("FAIL overflow: err=%b run=%b done=%b cnt=%0d sum=%h required 1 0 0 16 20",
                     load_err, cpu_run, load_done, byte_count, checksum);
        end
        in_valid = 1'b1; in_data = 8'h99;
        repeat (3) begin
            tick();
            checks++;
            if ({in_ready, mem_we, load_err} !== 3'b001) begin
                errors++;
                $display("FAIL overflow_hold: rdy=%b we=%b err=%b required 0 0 1",
                         in_ready, mem_we, load_err);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        start_and_clear();
        send_byte(8'hA1, 1'b0, 1'b1, 4'd0);
        send_byte(8'hA2, 1'b0, 1'b1, 4'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({in_ready, mem_we} !== 2'b10) begin
            errors++;
            $display("FAIL start_ignored: in_ready=%b mem_we=%b required 1 0", in_ready, mem_we);
        end
        for (int i = 2; i < 5; i++)
            send_byte(8'hA0 + 8'(i + 1), 1'b0, 1'b1, AW'(i));
        checks++;
        if (byte_count !== 5'd5) begin
            errors++;
            $display("FAIL mid_count: byte_count=%0d required 5", byte_count);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata, cpu_run, load_done, load_err, byte_count,
             checksum, in_ready} !== '0) begin
            errors++;
            $display("FAIL mid_reset: we=%b addr=%h wd=%h cnt=%0d sum=%h rdy=%b required all 0",
                     mem_we, mem_addr, mem_wdata, byte_count, checksum, in_ready);
        end
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < MB; i++) begin
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, AW'(i), 8'h00}) begin
                errors++;
                $display("FAIL restart_sweep[%0d]: we=%b addr=%h wd=%h required 1 %h 00",
                         i, mem_we, mem_addr, mem_wdata, AW'(i));
            end
            tick();
        end
    endtask

    // Random images checked against a zero-filled memory model plus running sum.
    task automatic test_random_images();
        for (int t = 0; t < 4; t++) begin
            int         n;
            int         w0;
            int         bad;
            int         sum;
            logic [7:0] img [MB];
            logic [7:0] exp_mem [MB];
            n   = $urandom_range(1, MB);
            sum = 0;
            for (int i = 0; i < MB; i++) exp_mem[i] = 8'h00;
            for (int i = 0; i < n; i++) begin
                img[i]     = 8'($urandom_range(1, 255));
                exp_mem[i] = img[i];
                sum        = sum + int'(img[i]);
            end
            do_reset();
            w0 = wr_count;
            start_and_clear();
            for (int i = 0; i < n; i++) begin
                send_byte(img[i], (i == n - 1), 1'b1, AW'(i));
                repeat ($urandom_range(0, 2)) tick();
            end
            tick();
            checks++;
            if ({load_done, cpu_run, load_err, byte_count, checksum} !==
                {3'b110, 5'(n), 8'(sum % 256)}) begin
                errors++;
                $display("FAIL rand_status[%0d]: done=%b run=%b err=%b cnt=%0d sum=%h required 1 1 0 %0d %h",
                         t, load_done, cpu_run, load_err, byte_count, checksum, n, 8'(sum % 256));
            end
            bad = 0;
            for (int i = 0; i < MB; i++)
                if (obs_mem[i] !== exp_mem[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_image[%0d]: %0d bytes differ, required 0", t, bad);
            end
            checks++;
            if (wr_count - w0 != MB + n) begin
                errors++;
                $display("FAIL rand_writes[%0d]: %0d writes, required %0d", t, wr_count - w0, MB + n);
            end
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_clear();
        test_load_gaps();
        test_exact_fill();
        test_overflow();
        test_reset_mid_load();
        test_random_images();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
